// File: rtl/ocm_access_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port (PS OCM slave) between NREQ PL requesters.
// One single-beat transaction in flight at a time; every output is driven straight from a flop.
module ocm_access_arbiter #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic [ADDR_W-1:0]        m_axi_awaddr,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [DATA_W-1:0]        m_axi_wdata,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   input  logic [1:0]               m_axi_bresp,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,
   output logic [ADDR_W-1:0]        m_axi_araddr,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic [DATA_W-1:0]        m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready
);
   localparam int GW = $clog2(NREQ);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WADDR = 3'd1,
      S_WRESP = 3'd2,
      S_RADDR = 3'd3,
      S_RDATA = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       last_grant_q, last_grant_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic [NREQ-1:0]     req_ready_q, req_ready_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic [GW:0]         pick_s;
   logic [GW-1:0]       gidx_s;

   // Returns {found, index} of the first valid requester after 'last', wrapping modulo NREQ.
   function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [GW-1:0] last);
      logic [GW:0]   res;
      logic [GW-1:0] sel;
      int            idx;
      res = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end else begin
            idx = idx;
         end
         sel = GW'(idx);
         if (!res[GW] && valid[sel]) begin
            res = {1'b1, sel};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Next-state and next-output logic; RESP also arbitrates so a new grant follows the completion pulse.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      req_ready_d  = '0;
      rsp_valid_d  = '0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      awaddr_d     = awaddr_q;
      wdata_d      = wdata_q;
      araddr_d     = araddr_q;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      pick_s       = rr_pick(req_valid, last_grant_q);
      gidx_s       = pick_s[GW-1:0];
      case (state_q)
         S_IDLE, S_RESP: begin
            if (pick_s[GW]) begin
               grant_d      = gidx_s;
               last_grant_d = gidx_s;
               req_ready_d  = {{(NREQ-1){1'b0}}, 1'b1} << gidx_s;
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               if (req_write[gidx_s]) begin
                  state_d  = S_WADDR;
                  awaddr_d = ADDR_W'(req_addr >> (int'(gidx_s) * ADDR_W));
                  wdata_d  = DATA_W'(req_wdata >> (int'(gidx_s) * DATA_W));
               end else begin
                  state_d  = S_RADDR;
                  araddr_d = ADDR_W'(req_addr >> (int'(gidx_s) * ADDR_W));
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WADDR: begin
            // AW and W complete independently; each valid drops right after its own handshake.
            aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
            w_done_d  = w_done_q | (wvalid_q & m_axi_wready);
            awvalid_d = ~aw_done_d;
            wvalid_d  = ~w_done_d;
            if (aw_done_d && w_done_d) begin
               state_d  = S_WRESP;
               bready_d = 1'b1;
            end else begin
               state_d = S_WADDR;
            end
         end
         S_WRESP: begin
            if (bready_q && m_axi_bvalid) begin
               state_d     = S_RESP;
               rsp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
               rsp_err_d   = (m_axi_bresp != 2'b00);
               rsp_rdata_d = '0;
            end else begin
               bready_d = 1'b1;
            end
         end
         S_RADDR: begin
            if (arvalid_q && m_axi_arready) begin
               state_d  = S_RDATA;
               rready_d = 1'b1;
            end else begin
               arvalid_d = 1'b1;
            end
         end
         S_RDATA: begin
            if (rready_q && m_axi_rvalid) begin
               state_d     = S_RESP;
               rsp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
               rsp_err_d   = (m_axi_rresp != 2'b00);
               rsp_rdata_d = m_axi_rdata;
            end else begin
               rready_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction without a completion pulse.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= S_IDLE;
         last_grant_q <= GW'(NREQ - 1);
         grant_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         req_ready_q  <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         awaddr_q     <= '0;
         wdata_q      <= '0;
         araddr_q     <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         awaddr_q     <= awaddr_d;
         wdata_q      <= wdata_d;
         araddr_q     <= araddr_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
endmodule
